// File: rtl/voice_sample_buffer_pkg.sv
// voice_pkg: shared state encoding and frame geometry for the voice sample buffer
package voice_pkg;
  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} buf_state_t;
  localparam int VOICE_FRAME_DEPTH = 128;
  localparam int VOICE_SAMPLE_W = 8;
endpackage

// File: rtl/voice_sample_buffer_mem.sv
// voice_sample_mem: DEPTH x WIDTH simple dual-port RAM, 1-cycle registered read, array not reset
// ports: clk; we/waddr/wdata write port; raddr in, rdata out one cycle later
module voice_sample_mem import voice_pkg::*; #(
  parameter int WIDTH = VOICE_SAMPLE_W,
  parameter int DEPTH = VOICE_FRAME_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/voice_sample_buffer.sv
// voice_sample_buffer: captures one frame of recorder bytes, holds it, then streams it out over valid/ready
// ports: clk, reset_L (async active-low); start arms a fill; wr_en/wr_data sample strobe;
//        drain starts streaming a held frame; out_valid/out_ready/out_data/out_last stream;
//        full, busy, overrun (sticky), fill_count, done (1-cycle end-of-drain pulse)
// build option: VOICE_SAMPLE_BUF_POPCOUNT_EN stores the popcount of each byte instead of the raw byte
module voice_sample_buffer import voice_pkg::*; #(
  parameter int WIDTH = VOICE_SAMPLE_W,
  parameter int DEPTH = VOICE_FRAME_DEPTH,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              start,
  input  logic              wr_en,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              drain,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              full,
  output logic              busy,
  output logic              overrun,
  output logic [ADDR_W:0]   fill_count,
  output logic              done
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH-1);
  buf_state_t state, state_nx;
  logic [ADDR_W-1:0] wr_ptr, out_cnt;
  logic [ADDR_W:0] rd_ptr;
  logic [WIDTH-1:0] wdata, rdata, pf_data;
  logic [1:0] occ;
  logic we, re, pop, hold, last_hs, rd_pend, pf_valid;
`ifdef VOICE_SAMPLE_BUF_POPCOUNT_EN
  always_comb begin
    wdata = '0;
    for (int i = 0; i < WIDTH; i++) wdata = wdata + WIDTH'(wr_data[i]);
  end
`else
  assign wdata = wr_data;
`endif
  assign we = state == FILL && wr_en && !start;
  assign pop = out_valid && out_ready;
  assign hold = out_valid && !out_ready;
  assign out_last = out_valid && out_cnt == ADDR_W'(DEPTH-1);
  assign last_hs = pop && out_last;
  assign busy = state == FILL || state == DRAIN;
  // items held or in flight after this cycle's pop; a read is issued only if its data will have a slot
  assign occ = {1'b0, out_valid} + {1'b0, pf_valid} + {1'b0, rd_pend} - {1'b0, pop};
  // the first read goes out in the drain cycle itself so data reaches the output two cycles later
  assign re = !start && ((state == HOLD && drain) ||
                         (state == DRAIN && rd_ptr != FULL_CNT && occ < 2'd2));
  voice_sample_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk(clk), .we(we), .waddr(wr_ptr), .wdata(wdata),
    .raddr(rd_ptr[ADDR_W-1:0]), .rdata(rdata)
  );
  always_comb begin
    state_nx = start ? FILL :
               (we && fill_count == LAST_CNT) ? HOLD :
               (state == HOLD && drain) ? DRAIN :
               (state == DRAIN && last_hs) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_cnt <= '0;
      fill_count <= '0;
      full <= 1'b0;
      overrun <= 1'b0;
      done <= 1'b0;
      rd_pend <= 1'b0;
      pf_valid <= 1'b0;
      pf_data <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else if (start) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      out_cnt <= '0;
      fill_count <= '0;
      full <= 1'b0;
      overrun <= 1'b0;
      done <= 1'b0;
      rd_pend <= 1'b0;
      pf_valid <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      done <= last_hs;
      rd_pend <= re;
      if (re) rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
      if (we) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (we) fill_count <= fill_count + (ADDR_W+1)'(1);
      if (we && fill_count == LAST_CNT) full <= 1'b1;
      if (wr_en && (state == HOLD || state == DRAIN)) overrun <= 1'b1;
      if (pop) out_cnt <= out_cnt + ADDR_W'(1);
      // output register refills from the prefetch entry first, then from the arriving read
      out_valid <= hold || pf_valid || rd_pend;
      if (!hold && (pf_valid || rd_pend)) out_data <= pf_valid ? pf_data : rdata;
      pf_valid <= hold ? (pf_valid || rd_pend) : (pf_valid && rd_pend);
      if (rd_pend && (hold ? !pf_valid : pf_valid)) pf_data <= rdata;
      if (last_hs) begin
        full <= 1'b0;
        fill_count <= '0;
        rd_ptr <= '0;
      end
    end
  end
endmodule

// File: tb/tb_voice_sample_buffer.sv
// tb_voice_sample_buffer: randomized scenario bench for voice_sample_buffer against a frame-queue model
module tb_voice_sample_buffer;
  import voice_pkg::*;
  localparam int W = VOICE_SAMPLE_W;
  localparam int D = VOICE_FRAME_DEPTH;
  localparam int AW = $clog2(D);
  logic clk = 1'b0, reset_L = 1'b0, start = 1'b0, wr_en = 1'b0, drain = 1'b0, out_ready = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic out_valid, out_last, full, busy, overrun, done;
  logic [W-1:0] out_data;
  logic [AW:0] fill_count;
  int vectors = 0, miscompares = 0;
  logic [W-1:0] exp_q[$];
  always #5 clk = ~clk;
  voice_sample_buffer dut (
    .clk(clk), .reset_L(reset_L), .start(start), .wr_en(wr_en), .wr_data(wr_data),
    .drain(drain), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .full(full), .busy(busy), .overrun(overrun),
    .fill_count(fill_count), .done(done)
  );
  function automatic logic [W-1:0] model_store(input logic [W-1:0] d);
`ifdef VOICE_SAMPLE_BUF_POPCOUNT_EN
    return W'($countones(d));
`else
    return d;
`endif
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_q.delete();
  endtask
  // mode 0: value = index in frame, 1: constant val, 2: random with random idle gaps
  task automatic write_n(input int n, input int mode, input logic [W-1:0] val);
    logic [W-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = mode == 0 ? W'(exp_q.size()) : mode == 1 ? val : W'($urandom);
      if (mode == 2) repeat ($urandom_range(0, 2)) tick();
      wr_en = 1'b1;
      wr_data = d;
      tick();
      wr_en = 1'b0;
      exp_q.push_back(model_store(d));
    end
  endtask
  // ready mode 0: held high, 1: 1,0,0,1 pattern, 2: random; stops after 'target' handshakes
  task automatic run_drain(input int mode, input int target);
    int k = 0;
    logic rdy, stalled = 1'b0;
    logic [W-1:0] prev = '0;
    drain = 1'b1;
    tick();
    drain = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL early_valid: out_valid=%b expected 0 one cycle after drain", out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL first_valid: out_valid=%b expected 1 two cycles after drain", out_valid);
    end
    for (int cyc = 0; cyc < 8 * D + 50 && k < target; cyc++) begin
      rdy = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'($urandom_range(0, 1));
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== prev) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, prev);
        end
      end
      if (out_valid === 1'b1) begin
        vectors++;
        if (out_last !== (k == D - 1)) begin
          miscompares++;
          $display("FAIL out_last: sample %0d last=%b expected %b", k, out_last, k == D - 1);
        end
      end
      if (out_valid === 1'b1 && rdy) begin
        vectors++;
        if (out_data !== exp_q[k]) begin
          miscompares++;
          $display("FAIL sample: index %0d got %h expected %h", k, out_data, exp_q[k]);
        end
        k++;
      end
      stalled = out_valid === 1'b1 && !rdy;
      prev = out_data;
      out_ready = rdy;
      tick();
    end
    out_ready = 1'b0;
    vectors++;
    if (k != target) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d handshakes expected %0d", k, target);
    end
    if (target == D) begin
      vectors++;
      if (done !== 1'b1 || full !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || fill_count !== '0) begin
        miscompares++;
        $display("FAIL drain_end: done=%b full=%b valid=%b busy=%b fill=%0d expected 1 0 0 0 0",
                 done, full, out_valid, busy, fill_count);
      end
      tick();
      vectors++;
      if (done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_width: done=%b expected 0 on second cycle", done);
      end
    end
  endtask
  task automatic test_reset();
    reset_L = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({out_valid, out_last, full, busy, overrun, done} !== 6'b0 || fill_count !== '0 || out_data !== '0) begin
      miscompares++;
      $display("FAIL reset: flags=%b fill=%0d data=%h expected all 0",
               {out_valid, out_last, full, busy, overrun, done}, fill_count, out_data);
    end
    reset_L = 1'b1;
    tick();
    write_n(3, 2, '0);
    exp_q.delete();
    drain = 1'b1;
    tick();
    drain = 1'b0;
    repeat (3) tick();
    vectors++;
    if (fill_count !== '0 || overrun !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ignore: fill=%0d overrun=%b busy=%b valid=%b expected 0 0 0 0",
               fill_count, overrun, busy, out_valid);
    end
  endtask
  task automatic test_fill();
    pulse_start();
    vectors++;
    if (busy !== 1'b1 || fill_count !== '0 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL armed: busy=%b fill=%0d full=%b expected 1 0 0", busy, fill_count, full);
    end
    write_n(D - 1, 0, '0);
    vectors++;
    if (full !== 1'b0 || fill_count !== (AW+1)'(D - 1)) begin
      miscompares++;
      $display("FAIL almost_full: full=%b fill=%0d expected 0 %0d", full, fill_count, D - 1);
    end
    write_n(1, 0, '0);
    vectors++;
    if (full !== 1'b1 || fill_count !== (AW+1)'(D) || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full: full=%b fill=%0d busy=%b expected 1 %0d 0", full, fill_count, busy, D);
    end
  endtask
  task automatic test_drain_ready();
    run_drain(0, D);
  endtask
  task automatic test_drain_toggle();
    pulse_start();
    write_n(D, 0, '0);
    run_drain(1, D);
  endtask
  task automatic test_overrun();
    pulse_start();
    write_n(D, 2, '0);
    wr_en = 1'b1;
    wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    vectors++;
    if (overrun !== 1'b1 || full !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_set: overrun=%b full=%b expected 1 1", overrun, full);
    end
    run_drain(2, D);
    vectors++;
    if (overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_sticky: overrun=%b expected 1", overrun);
    end
    pulse_start();
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL overrun_clear: overrun=%b expected 0", overrun);
    end
  endtask
  task automatic test_restart();
    pulse_start();
    write_n(50, 2, '0);
    pulse_start();
    vectors++;
    if (fill_count !== '0) begin
      miscompares++;
      $display("FAIL restart_clear: fill=%0d expected 0", fill_count);
    end
    write_n(D - 1, 1, 8'hFF);
    vectors++;
    if (full !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_early_full: full=%b expected 0", full);
    end
    write_n(1, 1, 8'hFF);
    vectors++;
    if (full !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_full: full=%b expected 1", full);
    end
    run_drain(2, D);
  endtask
  task automatic test_collision();
    start = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h5A;
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    exp_q.delete();
    vectors++;
    if (fill_count !== '0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL start_write: fill=%0d busy=%b expected 0 1", fill_count, busy);
    end
    write_n(D, 2, '0);
    start = 1'b1;
    drain = 1'b1;
    tick();
    start = 1'b0;
    drain = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    vectors++;
    if (busy !== 1'b1 || full !== 1'b0 || fill_count !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL start_drain: busy=%b full=%b fill=%0d valid=%b expected 1 0 0 0",
               busy, full, fill_count, out_valid);
    end
    write_n(D, 2, '0);
    run_drain(2, D);
  endtask
  task automatic test_reset_mid_drain();
    pulse_start();
    write_n(D, 2, '0);
    run_drain(0, 60);
    reset_L = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || full !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_drain: valid=%b full=%b busy=%b done=%b expected 0 0 0 0",
               out_valid, full, busy, done);
    end
    tick();
    reset_L = 1'b1;
    tick();
    drain = 1'b1;
    out_ready = 1'b1;
    tick();
    drain = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL drain_ignored: cycle %0d valid=%b busy=%b done=%b expected 0 0 0",
                 i, out_valid, busy, done);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask
  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      write_n(D, 2, '0);
      run_drain(2, D);
    end
  endtask
  initial begin
    test_reset();
    test_fill();
    test_drain_ready();
    test_drain_toggle();
    test_overrun();
    test_restart();
    test_collision();
    test_reset_mid_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/voice_sample_buffer.md
Name: voice_sample_buffer

Overview:
Downstream stage of the voice recorder. Captures the byte stream (store_wr/store_data) produced from the mic bitstream into an on-chip sample RAM. Once a full frame is held, it streams the frame out to the FFT stage over a valid/ready handshake. It decouples the bursty, mic-paced writer from the FFT consumer and owns frame arm, fill, hold and drain sequencing.

Parameters:
WIDTH, 8, bits per stored sample; matches the recorder byte width.
DEPTH, 128, samples per frame; must be a power of two, at least 4.
ADDR_W, $clog2(DEPTH), address width; derived, not overridden.

Ports:
clk  input  1  system clock (100 MHz)
reset_L  input  1  asynchronous active-low reset
start  input  1  1-cycle pulse: clear pointers and flags, arm a new frame fill
wr_en  input  1  sample strobe from recorder (store_wr)
wr_data  input  WIDTH  sample byte from recorder (store_data)
drain  input  1  1-cycle pulse: begin streaming a held frame
out_valid  output  1  out_data holds a valid sample
out_ready  input  1  consumer accepts the sample this cycle
out_data  output  WIDTH  streamed sample
out_last  output  1  high with the final sample (index DEPTH-1)
full  output  1  frame complete and held, not yet drained
busy  output  1  state is FILL or DRAIN
overrun  output  1  sticky: a write was dropped
fill_count  output  ADDR_W+1  samples written in the current frame (0..DEPTH)
done  output  1  1-cycle pulse after the last handshake

Behaviour:
- Reset (async, reset_L low): state IDLE. wr_ptr, rd_ptr, fill_count = 0. All outputs 0. RAM contents undefined.
- States: IDLE, FILL, HOLD, DRAIN.
- IDLE:
  - start -> FILL; fill_count and overrun cleared.
  - wr_en ignored and not flagged.
  - drain ignored.
- FILL:
  - Each wr_en writes mem[wr_ptr] <= wr_data; wr_ptr and fill_count increment.
  - The write with fill_count == DEPTH-1 moves to HOLD next cycle. full=1 from that cycle; fill_count = DEPTH.
- HOLD:
  - full=1.
  - wr_en sets overrun; data dropped; mem unchanged.
  - drain -> DRAIN with rd_ptr = 0.
- DRAIN:
  - RAM read is synchronous. First out_valid appears 2 cycles after the drain pulse.
  - Output register plus 1-entry prefetch sustains 1 sample/cycle while out_ready is held high.
  - out_data and out_valid are stable while out_valid=1 and out_ready=0. No sample is lost or repeated under arbitrary out_ready toggling.
  - out_last is asserted together with the sample at index DEPTH-1.
  - Handshake on the last sample: next cycle is IDLE, done=1 for 1 cycle, full=0, fill_count=0.
  - full stays 1 through DRAIN until the last handshake.
  - wr_en sets overrun.
- start priority: start in any state aborts the current activity, clears pointers, overrun, fill_count, out_valid and full, and enters FILL next cycle.
- Simultaneous start and wr_en: the write is discarded; the fill begins on the following strobe.
- Simultaneous drain and start: start wins.
- drain outside HOLD is ignored.
- wr_ptr wraps naturally at DEPTH. It is never used past DEPTH-1 because FILL exits first.
- Reset mid-FILL or mid-DRAIN: immediate return to reset values; no partial done pulse.
- Stored order equals arrival order. out_data index k equals the k-th accepted write.

Optional Feature:
Macro VOICE_SAMPLE_BUF_POPCOUNT_EN.
- Defined: each accepted wr_data is replaced by its population count (number of 1 bits, 0..WIDTH), zero-extended to WIDTH, before the RAM write. This gives a crude PDM-to-PCM density value per byte. Pointer and handshake timing are unchanged; the count is combinational on the write path.
- Undefined: raw wr_data is stored.

Decomposition:
- Shared package voice_pkg:
  - enum buf_state_t {IDLE, FILL, HOLD, DRAIN}
  - localparam VOICE_FRAME_DEPTH = 128
  - localparam VOICE_SAMPLE_W = 8
- One sub-module, voice_sample_mem: simple dual-port synchronous RAM, DEPTH x WIDTH. One write port, one read port, 1-cycle read latency, no reset on the array.

Test Plan:
1. Reset, start, 128 writes of data i (0x00..0x7F) -> full=1 exactly 1 cycle after the 128th write; fill_count=128; busy=0.
2. From scenario 1, drain with out_ready held at 1 -> out_valid 2 cycles later; 128 consecutive samples 0x00..0x7F; out_last only on 0x7F; done pulse next cycle; full=0.
3. Same frame, out_ready toggled in a 1,0,0,1 pattern -> exactly 128 handshakes in order, out_data stable while stalled.
4. Write 0xAA while in HOLD -> overrun=1; drained frame unchanged; the next start clears overrun to 0.
5. start after 50 writes, then 128 writes of 0xFF -> full=1 at the 128th new write; all drained samples 0xFF (0x08 with VOICE_SAMPLE_BUF_POPCOUNT_EN).
6. reset_L low at sample 60 of a drain -> same cycle: out_valid=0, full=0, busy=0; after release, drain pulse ignored until a new frame is filled.
